// File: rtl/mem_image_rd_ctrl_if.sv
// Complex word types and the output stream interface for mem_image_rd_ctrl.
// The controller drives the master modport and the MAC array drives the slave modport.
package mem_image_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

  typedef complex_t [0:3][0:3] cword_t;
endpackage

interface mem_image_rd_ctrl_if;
  import mem_image_pkg::*;

  cword_t out_data;
  logic   out_valid;
  logic   out_ready;
  logic   out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/mem_image_rd_ctrl.sv
// Read-side sequencer for the ping-pong image memory: sweeps each filled bank num_passes times
// through a credit-limited skid FIFO. Define MEM_RD_CTRL_PERF_EN to add the perf_stall_cnt output.
module mem_image_rd_ctrl
  import mem_image_pkg::*;
#(
  parameter int IMAGE_MEM_DEPTH_BITS = 13,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bank_fill_done,
  input  logic                            bank_fill_sel,
  input  logic [IMAGE_MEM_DEPTH_BITS:0]   num_words,
  input  logic [7:0]                      num_passes,
  output logic [1:0]                      bank_full,
  output logic [IMAGE_MEM_DEPTH_BITS-1:0] read_address,
  output logic                            select_block_rd,
  input  cword_t                          mem_data,
  mem_image_rd_ctrl_if.master             out_if,
  output logic                            err_overrun
`ifdef MEM_RD_CTRL_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cnt
`endif
);

  localparam int AW    = IMAGE_MEM_DEPTH_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state;
  logic            cur_bank;
  logic [7:0]      pass;
  logic [AW-1:0]   last_addr;
  logic [7:0]      last_pass;

  logic            in_flight;
  logic            in_flight_last;
  cword_t          fifo_data [FIFO_DEPTH];
  logic            fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0]  occupancy;
  logic            issue;
  logic            issue_last;
  logic            fifo_valid;
  logic            pop;
  logic            last_beat;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight plus stored words never exceed the FIFO, so a landing word always has a slot.
  assign occupancy  = {{CNT_W{1'b0}}, in_flight} + {1'b0, count};
  assign issue      = (state == READ) && (occupancy < DEPTH_C);
  assign issue_last = issue && (read_address == last_addr) && (pass == last_pass);
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid && out_if.out_ready;
  assign last_beat  = pop && fifo_last[rd_ptr];

  assign out_if.out_valid = fifo_valid;
  assign out_if.out_data  = fifo_valid ? fifo_data[rd_ptr] : '0;
  assign out_if.out_last  = fifo_valid && fifo_last[rd_ptr];

  // Clearing is gated by the bank being full, so a set and a clear never meet on one bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full   <= '0;
      err_overrun <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (last_beat && (cur_bank == 1'(b)))
          bank_full[b] <= 1'b0;
        else if (bank_fill_done && (bank_fill_sel == 1'(b)) && !bank_full[b])
          bank_full[b] <= 1'b1;
      end
      if (bank_fill_done && bank_full[bank_fill_sel])
        err_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cur_bank        <= 1'b0;
      read_address    <= '0;
      select_block_rd <= 1'b0;
      pass            <= '0;
      last_addr       <= '0;
      last_pass       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bank_full[cur_bank]) begin
            last_addr       <= (num_words == '0) ? '0 : AW'(num_words - 1'b1);
            last_pass       <= (num_passes == '0) ? '0 : num_passes - 8'd1;
            read_address    <= '0;
            pass            <= '0;
            select_block_rd <= cur_bank;
            state           <= READ;
          end
        end
        READ: begin
          if (issue) begin
            if (read_address == last_addr) begin
              if (pass == last_pass) begin
                state <= DRAIN;
              end else begin
                read_address <= '0;
                pass         <= pass + 8'd1;
              end
            end else begin
              read_address <= read_address + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_beat) begin
            cur_bank <= ~cur_bank;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue_last;
      if (in_flight) wr_ptr <= next_ptr(wr_ptr);
      if (pop)       rd_ptr <= next_ptr(rd_ptr);
      if (in_flight && !pop)
        count <= count + 1'b1;
      else if (!in_flight && pop)
        count <= count - 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; count qualifies every entry and out_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (in_flight) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_last[wr_ptr] <= in_flight_last;
    end
  end

`ifdef MEM_RD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      perf_stall_cnt <= '0;
    else if (fifo_valid && !out_if.out_ready && (perf_stall_cnt != '1))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_image_rd_ctrl.sv
// Self-checking bench for mem_image_rd_ctrl: a RAM model with address-tagged words, a beat
// scoreboard, hand-written latency/switch/overrun/reset sequences and a table of bank sweeps.
module tb_mem_image_rd_ctrl;
  import mem_image_pkg::*;

  localparam int AW = 13;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
  } beat_t;

  typedef struct {
    int nw;
    int np;
    int mode;
    int exp_beats;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bank_fill_done = 1'b0;
  logic          bank_fill_sel = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [7:0]    num_passes = '0;
  logic [1:0]    bank_full;
  logic [AW-1:0] read_address;
  logic          select_block_rd;
  cword_t        mem_data;
  logic          err_overrun;
`ifdef MEM_RD_CTRL_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  mem_image_rd_ctrl_if sif ();

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     beats = 0;
  int     stalls = 0;
  int     stall_base = 0;
  int     first_cyc [2] = '{-1, -1};
  int     last_cyc [2] = '{-1, -1};
  int     ready_mode = 0;
  beat_t  sb [$];

  logic   prev_stall = 1'b0;
  cword_t prev_data;
  logic   prev_last;

  mem_image_rd_ctrl dut (
`ifdef MEM_RD_CTRL_PERF_EN
    .perf_stall_cnt  (perf_stall_cnt),
`endif
    .clk             (clk),
    .reset           (reset),
    .bank_fill_done  (bank_fill_done),
    .bank_fill_sel   (bank_fill_sel),
    .num_words       (num_words),
    .num_passes      (num_passes),
    .bank_full       (bank_full),
    .read_address    (read_address),
    .select_block_rd (select_block_rd),
    .mem_data        (mem_data),
    .out_if          (sif.master),
    .err_overrun     (err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cword_t word_of(input logic bank, input logic [AW-1:0] addr);
    cword_t w;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w[i][j].re = {bank, addr, 2'(j)};
        w[i][j].im = (16'(addr) * 16'd3 + 16'(i * 4 + j)) ^ {bank, 15'h02a5};
      end
    end
    return w;
  endfunction

  // RAM model: one cycle from address to data, tagged with bank and address.
  always @(posedge clk) mem_data <= word_of(select_block_rd, read_address);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input cword_t act, input cword_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    int rphase = 0;
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rphase = (rphase == 2) ? 0 : rphase + 1;
      case (ready_mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = (rphase == 0);
        default: sif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each transferred beat and checks stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(sif.out_valid), 64'(1));
        check_word("stall_data", sif.out_data, prev_data);
        check("stall_last", 64'(sif.out_last), 64'(prev_last));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          check_word("beat_data", sif.out_data, word_of(e.bank, e.addr));
          check("beat_last", 64'(sif.out_last), 64'(e.last));
          if (e.first) first_cyc[e.bank] = cyc;
          last_cyc[e.bank] = cyc;
          beats++;
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      if (prev_stall) stalls++;
      prev_data = sif.out_data;
      prev_last = sif.out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bank_fill_done = 1'b0;
    step();
    step();
    sb.delete();
    reset = 1'b0;
    stall_base = stalls;
  endtask

  task automatic push_bank(input logic bank, input int nw, input int np);
    int w = (nw == 0) ? 1 : nw;
    int p = (np == 0) ? 1 : np;
    for (int pi = 0; pi < p; pi++) begin
      for (int a = 0; a < w; a++) begin
        sb.push_back('{bank: bank, addr: AW'(a), first: (pi == 0 && a == 0),
                       last: (pi == p - 1 && a == w - 1)});
      end
    end
  endtask

  task automatic fill(input logic sel);
    bank_fill_sel  = sel;
    bank_fill_done = 1'b1;
    step();
    bank_fill_done = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(sb.size()), 64'(0));
    repeat (3) step();
  endtask

  initial begin
    vec_t vecs [7];
    int   c0;
    int   base;
    int   n;
    logic bank;

    vecs[0] = '{nw: 1,    np: 3, mode: 0, exp_beats: 3};
    vecs[1] = '{nw: 1,    np: 0, mode: 0, exp_beats: 1};
    vecs[2] = '{nw: 0,    np: 2, mode: 0, exp_beats: 2};
    vecs[3] = '{nw: 3,    np: 0, mode: 2, exp_beats: 3};
    vecs[4] = '{nw: 5,    np: 2, mode: 2, exp_beats: 10};
    vecs[5] = '{nw: 2,    np: 4, mode: 1, exp_beats: 8};
    vecs[6] = '{nw: 8192, np: 2, mode: 0, exp_beats: 16384};

    // Reset values
    do_reset();
    check("rst_bank_full", 64'(bank_full), 64'(0));
    check("rst_out_valid", 64'(sif.out_valid), 64'(0));
    check("rst_out_last", 64'(sif.out_last), 64'(0));
    check("rst_err", 64'(err_overrun), 64'(0));
    check("rst_select", 64'(select_block_rd), 64'(0));
    check_word("rst_out_data", sif.out_data, '0);

    // Single bank, latency and back-to-back beats
    ready_mode = 0;
    num_words  = 14'd4;
    num_passes = 8'd2;
    base = beats;
    push_bank(1'b0, 4, 2);
    c0 = cyc;
    fill(1'b0);
    check("t1_full_c1", 64'(bank_full), 64'(2'b01));
    check("t1_valid_c1", 64'(sif.out_valid), 64'(0));
    step();
    check("t1_addr_c2", 64'(read_address), 64'(0));
    step();
    check("t1_addr_c3", 64'(read_address), 64'(1));
    check("t1_valid_c3", 64'(sif.out_valid), 64'(0));
    step();
    check("t1_valid_c4", 64'(sif.out_valid), 64'(1));
    wait_empty("t1_drain", 100);
    check("t1_beats", 64'(beats - base), 64'(8));
    check("t1_first_cyc", 64'(first_cyc[0] - c0), 64'(4));
    check("t1_span", 64'(last_cyc[0] - first_cyc[0]), 64'(7));
    check("t1_full_clr", 64'(bank_full), 64'(0));

    // Both banks filled back-to-back
    do_reset();
    num_words  = 14'd8;
    num_passes = 8'd1;
    base = beats;
    push_bank(1'b0, 8, 1);
    push_bank(1'b1, 8, 1);
    fill(1'b0);
    fill(1'b1);
    check("t2_full_both", 64'(bank_full), 64'(2'b11));
    wait_empty("t2_drain", 200);
    check("t2_beats", 64'(beats - base), 64'(16));
    check("t2_gap", 64'(first_cyc[1] - last_cyc[0]), 64'(4));
    check("t2_span1", 64'(last_cyc[1] - first_cyc[1]), 64'(7));
    check("t2_full_clr", 64'(bank_full), 64'(0));

    // Backpressure pattern 1,0,0
    do_reset();
    ready_mode = 1;
    num_words  = 14'd4;
    num_passes = 8'd2;
    base = beats;
    push_bank(1'b0, 4, 2);
    fill(1'b0);
    wait_empty("t3_drain", 200);
    check("t3_beats", 64'(beats - base), 64'(8));
    check("t3_stalled", 64'(stalls != stall_base), 64'(1));
`ifdef MEM_RD_CTRL_PERF_EN
    check("t3_perf", 64'(perf_stall_cnt), 64'(stalls - stall_base));
`endif
    ready_mode = 0;

    // Overrun on a bank that is still full
    do_reset();
    num_words  = 14'd8;
    num_passes = 8'd1;
    base = beats;
    push_bank(1'b0, 8, 1);
    fill(1'b0);
    check("t4_err_first", 64'(err_overrun), 64'(0));
    fill(1'b0);
    check("t4_err_set", 64'(err_overrun), 64'(1));
    wait_empty("t4_drain", 100);
    check("t4_beats", 64'(beats - base), 64'(8));
    check("t4_err_sticky", 64'(err_overrun), 64'(1));
    check("t4_full_clr", 64'(bank_full), 64'(0));

    // Table of sweeps; banks alternate 0,1,0,...
    do_reset();
    bank = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ready_mode = vecs[i].mode;
      num_words  = 14'(vecs[i].nw);
      num_passes = 8'(vecs[i].np);
      base = beats;
      push_bank(bank, vecs[i].nw, vecs[i].np);
      fill(bank);
      wait_empty($sformatf("vec%0d_drain", i), 4 * vecs[i].exp_beats + 50);
      check($sformatf("vec%0d_beats", i), 64'(beats - base), 64'(vecs[i].exp_beats));
      check($sformatf("vec%0d_full_clr", i), 64'(bank_full), 64'(0));
      bank = ~bank;
    end
    ready_mode = 0;

    // Reset in the middle of a sweep
    do_reset();
    num_words  = 14'd16;
    num_passes = 8'd1;
    base = beats;
    push_bank(1'b0, 16, 1);
    fill(1'b0);
    n = 0;
    while ((beats - base) < 5 && n < 50) begin
      step();
      n++;
    end
    check("t6_five_beats", 64'(beats - base), 64'(5));
    reset = 1'b1;
    sb.delete();
    step();
    check("t6_valid", 64'(sif.out_valid), 64'(0));
    check("t6_last", 64'(sif.out_last), 64'(0));
    check_word("t6_data", sif.out_data, '0);
    check("t6_addr", 64'(read_address), 64'(0));
    check("t6_select", 64'(select_block_rd), 64'(0));
    check("t6_full", 64'(bank_full), 64'(0));
    check("t6_err", 64'(err_overrun), 64'(0));
    reset = 1'b0;
    stall_base = stalls;
    num_words  = 14'd4;
    base = beats;
    push_bank(1'b0, 4, 1);
    c0 = cyc;
    fill(1'b0);
    wait_empty("t6_drain", 100);
    check("t6_beats", 64'(beats - base), 64'(4));
    check("t6_first_cyc", 64'(first_cyc[0] - c0), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
